// File: rtl/cdc_pkg.sv
// Shared types for the req/ack CDC receive controller.
//   cdc_rx_state_t : receive FSM state encoding (IDLE, VALID, ACK)
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } cdc_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchronizer cell for bringing asynchronous levels into clk.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronized output, two clk edges after d is first sampled
module sync_ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // First stage may go metastable; second stage gives it a cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdc_hs_rx.sv
// Receive-side controller for a 4-phase req/ack clock-domain crossing.
// Synchronizes async_req, captures the source's held data word, offers it to
// a local consumer with valid/ready, then returns async_ack to the source.
//   clk, rst    : destination clock, asynchronous active-high reset
//   async_req   : request from source domain (asynchronous)
//   async_data  : source word, held stable from req rise to ack rise
//   async_ack   : registered acknowledge back to the source domain
//   out_valid   : captured word available to the consumer
//   out_data    : captured word, stable while out_valid
//   out_ready   : consumer accept
//   busy        : controller not idle
//   xfer_count  : completed consumer transfers, wraps
//   proto_err   : sticky, source dropped req before acknowledge
module cdc_hs_rx
    import cdc_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             async_req,
    input  logic [W-1:0]     async_data,
    output logic             async_ack,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count,
    output logic             proto_err
);

    cdc_rx_state_t state;
    cdc_rx_state_t state_nxt;
    logic          req_s;
    logic          capture;
    logic          accept;
    logic          err_set;

    // async_data is not synchronized: the source holds it stable while req is up.
    sync_ff #(
        .W (1)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (async_req),
        .q   (req_s)
    );

    // Next-state and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        accept    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    capture   = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                // Source must keep req up until it sees ack; flag but still deliver.
                if (!req_s) begin
                    err_set = 1'b1;
                end
                if (out_ready) begin
                    accept    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; status outputs are flops decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            async_ack <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            async_ack <= (state_nxt == ACK);
            out_valid <= (state_nxt == VALID);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Data capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (capture) begin
            out_data <= async_data;
        end
    end

    // Completed-transfer counter, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (accept) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (err_set) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Self-checking bench for cdc_hs_rx: transfer-level reference model,
// per-cycle output compare, data-order scoreboard and directed literal checks.
module tb_cdc_hs_rx;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             async_req  = 1'b0;
    logic [W-1:0]     async_data = '0;
    logic             out_ready  = 1'b0;
    logic             async_ack;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             busy;
    logic [CNT_W-1:0] xfer_count;
    logic             proto_err;

    cdc_hs_rx #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .async_req  (async_req),
        .async_data (async_data),
        .async_ack  (async_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .xfer_count (xfer_count),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A word is "offered" once the request has been seen (two edges after first
    // sample) while the link is idle; "acknowledged" from consumer accept until
    // the dropped request has been seen.
    bit           m_offer = 1'b0;
    bit           m_acked = 1'b0;
    bit           m_err   = 1'b0;
    logic [W-1:0] m_word  = '0;
    int unsigned  m_cnt   = 0;
    bit           samp[$];
    logic [W-1:0] sb[$];

    always @(posedge clk or posedge rst) begin
        bit seen;
        if (rst) begin
            m_offer = 1'b0;
            m_acked = 1'b0;
            m_err   = 1'b0;
            m_word  = '0;
            m_cnt   = 0;
            samp.delete();
            sb.delete();
        end else begin
            seen = (samp.size() >= 2) ? samp[0] : 1'b0;
            if (m_offer) begin
                if (!seen) m_err = 1'b1;
                if (out_ready) begin
                    m_offer = 1'b0;
                    m_acked = 1'b1;
                    m_cnt++;
                end
            end else if (m_acked) begin
                if (!seen) m_acked = 1'b0;
            end else if (seen) begin
                m_offer = 1'b1;
                m_word  = async_data;
            end
            samp.push_back(async_req);
            if (samp.size() > 2) void'(samp.pop_front());
        end
    end

    // Per-cycle comparison against the model, plus ordered data scoreboard.
    always @(negedge clk) begin
        check("valid", out_valid, m_offer);
        check("ack", async_ack, m_acked);
        check("busy", busy, m_offer | m_acked);
        check("data", out_data, m_word);
        check("count", xfer_count, m_cnt % 256);
        check("proto_err", proto_err, m_err);
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_order: got %0h expected nothing (no word sent) at %0t", out_data, $time);
            end else begin
                check("sb_order", out_data, sb.pop_front());
            end
        end
    end

    // ---------------- consumer ----------------
    bit rnd_ready = 1'b0;
    bit ready_val = 1'b1;

    always @(posedge clk) begin
        if (rnd_ready) begin
            #(1 + $urandom_range(3));
            out_ready = 1'($urandom_range(1));
        end else begin
            #1;
            out_ready = ready_val;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_out(input int sel, input bit val, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (((sel == 0) ? out_valid : async_ack) == val) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_%s: got no %0d within %0d cycles, required %0d", (sel == 0) ? "valid" : "ack", val, budget, val);
    endtask

    task automatic raise(input logic [W-1:0] word, input int unsigned dly);
        #(dly);
        async_data = word;
        async_req  = 1'b1;
        sb.push_back(word);
    endtask

    task automatic xfer(input logic [W-1:0] word, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk);
        raise(word, 1 + $urandom_range(3));
        wait_out(1, 1'b1, 400);
        repeat ($urandom_range(2)) @(posedge clk);
        @(posedge clk);
        #(1 + $urandom_range(3));
        async_req  = 1'b0;
        async_data = $urandom;
        wait_out(1, 1'b0, 50);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        // Reset values
        #12;
        check("rst_ack", async_ack, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", xfer_count, 8'd0);
        check("rst_err", proto_err, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single transfer with latency pinned in edges
        @(posedge clk);
        raise(32'hDEAD_BEEF, 2);
        @(posedge clk);                  // E0
        @(posedge clk);                  // E1
        @(negedge clk);
        check("t1_valid_e1", out_valid, 1'b0);
        @(posedge clk);                  // E2
        @(negedge clk);
        check("t1_valid_e2", out_valid, 1'b1);
        check("t1_data_e2", out_data, 32'hDEAD_BEEF);
        @(posedge clk);                  // E3
        #2 async_req = 1'b0;
        @(negedge clk);
        check("t1_valid_e3", out_valid, 1'b0);
        check("t1_ack_e3", async_ack, 1'b1);
        @(posedge clk);                  // F0
        @(posedge clk);                  // F1
        @(negedge clk);
        check("t1_ack_f1", async_ack, 1'b1);
        @(posedge clk);                  // F2
        @(negedge clk);
        check("t1_ack_f2", async_ack, 1'b0);
        check("t1_busy", busy, 1'b0);
        check("t1_count", xfer_count, 8'd1);

        // Consumer backpressure
        @(posedge clk);
        #2 ready_val = 1'b0;
        repeat (3) @(posedge clk);
        raise(32'hCAFE_0123, 2);
        wait_out(0, 1'b1, 20);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, 32'hCAFE_0123);
            check("bp_ack", async_ack, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #2 ready_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_valid", out_valid, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("bp_accept_ack", async_ack, 1'b1);
        check("bp_accept_valid", out_valid, 1'b0);
        @(posedge clk);
        #2 async_req = 1'b0;
        wait_out(1, 1'b0, 20);
        check("bp_count", xfer_count, 8'd2);

        // Protocol violation: request dropped while word is offered
        @(posedge clk);
        #2 ready_val = 1'b0;
        repeat (3) @(posedge clk);
        raise(32'h1234_5678, 3);
        wait_out(0, 1'b1, 20);
        @(posedge clk);
        #2 async_req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pe_flag", proto_err, 1'b1);
        check("pe_still_valid", out_valid, 1'b1);
        @(posedge clk);
        #2 ready_val = 1'b1;
        wait_out(1, 1'b1, 20);
        wait_out(1, 1'b0, 20);
        repeat (3) @(negedge clk);
        check("pe_idle", busy, 1'b0);
        check("pe_sticky", proto_err, 1'b1);
        check("pe_count", xfer_count, 8'd3);

        // Back-to-back random transfers with random consumer and source jitter
        do_reset();
        check("rr_err_cleared", proto_err, 1'b0);
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            xfer($urandom, $urandom_range(4));
        end
        rnd_ready = 1'b0;
        ready_val = 1'b1;
        repeat (3) @(negedge clk);
        check("rr_count", xfer_count, 8'd44);
        check("rr_err", proto_err, 1'b0);
        check("rr_sb_empty", 32'(sb.size()), 32'd0);

        // Mid-transfer asynchronous reset while acknowledging
        @(posedge clk);
        raise(32'hA5A5_5A5A, 2);
        wait_out(1, 1'b1, 20);
        #3 rst = 1'b1;
        #1;
        check("mr_ack", async_ack, 1'b0);
        check("mr_valid", out_valid, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_count", xfer_count, 8'd0);
        check("mr_data", out_data, 32'h0);
        async_req = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mr_after_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
